// File: rtl/mem_access_unit_pkg.sv
// Shared size codes, FSM encoding and byte-count helper for the
// byte-serial data-memory access unit.
package mem_access_unit_pkg;

  localparam logic [1:0] MR_NONE = 2'b00;
  localparam logic [1:0] MR_HALF = 2'b01;
  localparam logic [1:0] MR_WORD = 2'b10;
  localparam logic [1:0] MR_BYTE = 2'b11;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_TAIL,
    S_WR,
    S_FIN
  } state_t;

  // Read and write encodings order the sizes differently.
  function automatic logic [2:0] size_to_bytes(
    input logic       is_wr,
    input logic [1:0] code
  );
    logic [2:0] n;
    n = 3'd0;
    unique case (code)
      2'b01:   n = is_wr ? 3'd1 : 3'd2;
      2'b10:   n = is_wr ? 3'd2 : 3'd4;
      2'b11:   n = is_wr ? 3'd4 : 3'd1;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Sign-extends an assembled load word according to the MemRead code.
// LB extends bit 7, LH extends bit 15, LW passes through.
module mem_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [31:0] word,
  output logic [31:0] ext
);

  always_comb begin
    ext = word;
    unique case (size)
      MR_BYTE: ext = {{24{word[7]}}, word[7:0]};
      MR_HALF: ext = {{16{word[15]}}, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-serial load/store engine for an 8-bit data memory.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    MemRead,
  input  logic [1:0]    MemWrite,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  state_t      state;
  logic [2:0]  n;
  logic [2:0]  cnt;
  logic [1:0]  rcode;
  logic [1:0]  ridx;
  logic        rvalid;
  logic [31:0] rbuf;
  logic [23:0] wbuf;
  logic [31:0] asm_word;
  logic [31:0] ext_word;
  logic        req_wr;
  logic        req_any;
  logic [2:0]  req_n;
  logic        misal;
  logic        unused_addr;

  assign unused_addr = ^addr[DW-1:AW];

  assign req_wr  = MemWrite != MW_NONE;
  assign req_any = req_wr || (MemRead != MR_NONE);
  assign req_n   = req_wr ? size_to_bytes(1'b1, MemWrite)
                          : size_to_bytes(1'b0, MemRead);

`ifdef MEM_ALIGN_CHECK_EN
  assign misal = ((req_n == 3'd2) && addr[0]) ||
                 ((req_n == 3'd4) && (addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  // Final byte arrives in RD_TAIL; merge it without waiting a cycle.
  always_comb begin
    asm_word = rbuf;
    asm_word[{ridx, 3'b000} +: 8] = mem_rdata;
  end

  mem_load_extend u_ext (
    .size (rcode),
    .word (asm_word),
    .ext  (ext_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      n         <= 3'd0;
      cnt       <= 3'd0;
      rcode     <= MR_NONE;
      ridx      <= 2'd0;
      rvalid    <= 1'b0;
      rbuf      <= 32'd0;
      wbuf      <= 24'd0;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'd0;
    end else begin
      rvalid <= mem_re;
      if (rvalid && state == S_RD) begin
        rbuf[{ridx, 3'b000} +: 8] <= mem_rdata;
        ridx <= ridx + 2'd1;
      end
      unique case (state)
        S_IDLE: begin
          if (start && req_any) begin
            busy     <= 1'b1;
            cnt      <= 3'd1;
            n        <= req_n;
            rcode    <= MemRead;
            mem_addr <= addr[AW-1:0];
            rbuf     <= 32'd0;
            ridx     <= 2'd0;
            wbuf     <= wdata[31:8];
            if (misal) begin
              state <= S_FIN;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (req_wr) begin
              state     <= S_WR;
              mem_we    <= 1'b1;
              mem_wdata <= wdata[7:0];
            end else begin
              state  <= S_RD;
              mem_re <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (cnt < n) begin
            mem_addr <= mem_addr + 1'b1;
            cnt      <= cnt + 3'd1;
          end else begin
            mem_re <= 1'b0;
            state  <= S_RD_TAIL;
          end
        end
        S_RD_TAIL: begin
          rdata <= ext_word;
          done  <= 1'b1;
          state <= S_FIN;
        end
        S_WR: begin
          if (cnt < n) begin
            mem_addr  <= mem_addr + 1'b1;
            mem_wdata <= wbuf[7:0];
            wbuf      <= {8'h00, wbuf[23:8]};
            cnt       <= cnt + 3'd1;
          end else begin
            mem_we <= 1'b0;
            done   <= 1'b1;
            state  <= S_FIN;
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
